// File: rtl/firmware_loader_m.sv
// firmware_loader_m: boot-time copy engine. Reads SIZE bytes from the firmware ROM
// (combinational read) and writes them to shadow RAM at DST_BASE+i, holding the CPU
// in reset until the copy has completed.
//
// Optional feature macro: FIRMWARE_LOADER_CHECKSUM_EN adds checksum/checksum_ok.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              one-cycle request to (re)start a copy (ignored while busy)
//   rom_address        ROM byte address (ADDR_W bits), rom_data returns the byte same cycle
//   ram_address/wdata  shadow RAM write address/data, stable while ram_we is held
//   ram_we, ram_ready  write request / accept handshake
//   busy, done         copy in progress / last copy completed (sticky)
//   cpu_hold           CPU reset, released once done
//   checksum(_ok)      running byte sum mod 256 / done && sum matches EXPECTED_SUM
module firmware_loader_m #(
    parameter int unsigned SIZE         = 32'h3000,
    parameter int unsigned ADDR_W       = 14,
    parameter logic [15:0] DST_BASE     = 16'h0000,
    parameter bit          AUTO_START   = 1'b1,
    parameter logic [7:0]  EXPECTED_SUM = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [7:0]        rom_data,
    output logic [15:0]       ram_address,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic              ram_ready,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]        checksum,
    output logic              checksum_ok
`endif
);

    // Last index precomputed at ADDR_W bits so SIZE == 2**ADDR_W never overflows the compare.
    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(SIZE - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] index_d;
    logic [15:0]       ram_address_d;
    logic [7:0]        ram_wdata_d;
    logic              ram_we_d;
    logic              busy_d;
    logic              done_d;

    // The ROM address is the byte index itself.
    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rom_address <= '0;
            ram_address <= DST_BASE;
            ram_wdata   <= '0;
            ram_we      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cpu_hold    <= 1'b1;
        end else begin
            state       <= state_d;
            rom_address <= index_d;
            ram_address <= ram_address_d;
            ram_wdata   <= ram_wdata_d;
            ram_we      <= ram_we_d;
            busy        <= busy_d;
            done        <= done_d;
            cpu_hold    <= ~done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state;
        index_d       = rom_address;
        ram_address_d = ram_address;
        ram_wdata_d   = ram_wdata;
        ram_we_d      = ram_we;

        unique case (state)
            ST_IDLE: begin
                if (AUTO_START || start) begin
                    index_d = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ram_wdata_d   = rom_data;
                ram_address_d = DST_BASE + 16'(rom_address);
                ram_we_d      = 1'b1;
                state_d       = ST_WRITE;
            end
            ST_WRITE: begin
                if (ram_ready) begin
                    ram_we_d = 1'b0;
                    if (rom_address == LAST_INDEX) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = rom_address + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    index_d = '0;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_FETCH) || (state_d == ST_WRITE);
        done_d = (state_d == ST_DONE);
    end

`ifdef FIRMWARE_LOADER_CHECKSUM_EN
    logic [7:0] checksum_d;
    logic       checksum_ok_d;

    // Sum of accepted bytes; cleared when a new copy starts from DONE.
    always_comb begin
        checksum_d = checksum;
        if (state == ST_WRITE && ram_ready) begin
            checksum_d = checksum + ram_wdata;
        end else if (state == ST_DONE && start) begin
            checksum_d = '0;
        end
        checksum_ok_d = done_d && (checksum_d == EXPECTED_SUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum    <= '0;
            checksum_ok <= 1'b0;
        end else begin
            checksum    <= checksum_d;
            checksum_ok <= checksum_ok_d;
        end
    end
`endif

endmodule

// File: tb/tb_firmware_loader_m.sv
// Self-checking bench for firmware_loader_m: several independently reset instances
// (autostart, manual start, SIZE=1, full-size copy, optional checksum), a transaction
// model of the copy, a per-cycle compare process and directed literal expectations.
module tb_firmware_loader_m;

`ifdef FIRMWARE_LOADER_CHECKSUM_EN
    localparam int N = 6;
`else
    localparam int N = 4;
`endif

    function automatic int unsigned size_of(input int i);
        case (i)
            2:       return 1;
            3:       return 32'h3000;
            4, 5:    return 256;
            default: return 16;
        endcase
    endfunction

    function automatic logic [15:0] base_of(input int i);
        case (i)
            0:       return 16'h0020;
            1:       return 16'h1000;
            2, 3:    return 16'h4000;
            default: return 16'h8000;
        endcase
    endfunction

    function automatic bit auto_of(input int i);
        return (i != 1);
    endfunction

    function automatic logic [7:0] exp_of(input int i);
        return (i == 5) ? 8'h01 : 8'h00;
    endfunction

    // ROM contents: i ^ 8'hA5 for the copy instances, all 8'h01 for the checksum ones.
    function automatic logic [7:0] rom_fn(input int i, input logic [13:0] a);
        return (i >= 4) ? 8'h01 : (a[7:0] ^ 8'hA5);
    endfunction

    logic        clk = 1'b0;
    logic        rst_n    [N];
    logic        start    [N];
    logic        ready    [N];
    logic [13:0] rom_addr [N];
    logic [7:0]  rom_data [N];
    logic [15:0] ram_addr [N];
    logic [7:0]  wdata    [N];
    logic        we       [N];
    logic        busy     [N];
    logic        done     [N];
    logic        hold     [N];
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
    logic [7:0]  csum     [N];
    logic        cok      [N];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned AW = (g == 0) ? 4 : 14;
        logic [AW-1:0] ra;
        firmware_loader_m #(
            .SIZE        (size_of(g)),
            .ADDR_W      (AW),
            .DST_BASE    (base_of(g)),
            .AUTO_START  (auto_of(g)),
            .EXPECTED_SUM(exp_of(g))
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n[g]),
            .start      (start[g]),
            .rom_address(ra),
            .rom_data   (rom_data[g]),
            .ram_address(ram_addr[g]),
            .ram_wdata  (wdata[g]),
            .ram_we     (we[g]),
            .ram_ready  (ready[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .cpu_hold   (hold[g])
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
            ,
            .checksum   (csum[g]),
            .checksum_ok(cok[g])
`endif
        );
        assign rom_addr[g] = 14'(ra);
        assign rom_data[g] = rom_fn(g, rom_addr[g]);
    end

    task automatic chk(input string name, input int i, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[inst %0d] got=%0h expected=%0h at %0t", name, i, got, exp, $time);
        end
    endtask

    // Copy model: byte k of the current copy is fetched, then offered until accepted.
    int unsigned m_k    [N];
    bit          m_idle [N];
    bit          m_run  [N];
    bit          m_pend [N];
    bit          m_done [N];
    logic [7:0]  m_sum  [N];

    // Log of writes the DUT actually made.
    int unsigned wr_cnt   [N];
    logic [15:0] last_addr[N];
    logic [15:0] min_addr [N];
    logic [15:0] max_addr [N];
    logic [7:0]  img      [N][16];

    initial begin
        for (int i = 0; i < N; i++) begin
            m_k[i] = 0; m_idle[i] = 1'b1; m_run[i] = 1'b0; m_pend[i] = 1'b0;
            m_done[i] = 1'b0; m_sum[i] = 8'h00;
            wr_cnt[i] = 0; last_addr[i] = 16'h0000;
            min_addr[i] = 16'hFFFF; max_addr[i] = 16'h0000;
            for (int j = 0; j < 16; j++) img[i][j] = 8'h00;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst_n[i] && we[i] && ready[i]) begin
                int off;
                wr_cnt[i]++;
                last_addr[i] = ram_addr[i];
                if (ram_addr[i] < min_addr[i]) min_addr[i] = ram_addr[i];
                if (ram_addr[i] > max_addr[i]) max_addr[i] = ram_addr[i];
                off = int'(ram_addr[i]) - int'(base_of(i));
                if (off >= 0 && off < 16) img[i][off] = wdata[i];
            end
            if (!rst_n[i]) begin
                m_idle[i] = 1'b1; m_run[i] = 1'b0; m_pend[i] = 1'b0;
                m_done[i] = 1'b0; m_k[i] = 0; m_sum[i] = 8'h00;
            end else if (m_idle[i]) begin
                if (auto_of(i) || start[i]) begin
                    m_idle[i] = 1'b0; m_run[i] = 1'b1; m_k[i] = 0;
                end
            end else if (m_run[i]) begin
                if (!m_pend[i]) begin
                    m_pend[i] = 1'b1;
                end else if (ready[i]) begin
                    m_sum[i]  = m_sum[i] + rom_fn(i, 14'(m_k[i]));
                    m_pend[i] = 1'b0;
                    if (m_k[i] == size_of(i) - 1) begin
                        m_run[i]  = 1'b0;
                        m_done[i] = 1'b1;
                    end else begin
                        m_k[i]++;
                    end
                end
            end else if (m_done[i] && start[i]) begin
                m_done[i] = 1'b0; m_run[i] = 1'b1; m_k[i] = 0; m_sum[i] = 8'h00;
            end
        end
    end

    // Per-cycle compare of every instance against the model.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk("ram_we", i, 32'(we[i]), 32'(m_pend[i]));
            chk("busy", i, 32'(busy[i]), 32'(m_run[i]));
            chk("done", i, 32'(done[i]), 32'(m_done[i]));
            chk("cpu_hold", i, 32'(hold[i]), 32'(!m_done[i]));
            if (m_run[i] && !m_pend[i])
                chk("rom_address", i, 32'(rom_addr[i]), m_k[i]);
            if (m_pend[i]) begin
                chk("ram_address", i, 32'(ram_addr[i]), 32'(base_of(i) + 16'(m_k[i])));
                chk("ram_wdata", i, 32'(wdata[i]), 32'(rom_fn(i, 14'(m_k[i]))));
            end
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
            chk("checksum", i, 32'(csum[i]), 32'(m_sum[i]));
            chk("checksum_ok", i, 32'(cok[i]), 32'(m_done[i] && (m_sum[i] == exp_of(i))));
`endif
        end
    end

    // Runs one copy from its first FETCH cycle until done; returns the number of
    // clock edges from the start edge up to and including the one that raised done.
    task automatic copy_run(input int i, input int stall_byte, input int busy_pulse,
                            input int abort_byte, output int cyc);
        int          stall_cnt;
        bit          stalled;
        bit          fin;
        int          limit;
        logic [15:0] b;
        cyc = 0; stall_cnt = 0; stalled = 1'b0; fin = 1'b0;
        b = base_of(i);
        limit = 4 * int'(size_of(i)) + 64;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk("first_rom_address", i, 32'(rom_addr[i]), 32'h0);
                chk("first_busy", i, 32'(busy[i]), 32'h1);
                chk("first_ram_we", i, 32'(we[i]), 32'h0);
                chk("first_done", i, 32'(done[i]), 32'h0);
                chk("first_cpu_hold", i, 32'(hold[i]), 32'h1);
                start[i] = 1'b0;
            end
            if (cyc == busy_pulse) start[i] = 1'b1;
            if (cyc == busy_pulse + 1) start[i] = 1'b0;
            if (stall_byte >= 0) begin
                if (stalled && stall_cnt < 5) begin
                    stall_cnt++;
                    if (stall_cnt == 5) ready[i] = 1'b1;
                end else if (!stalled && we[i] && ram_addr[i] == b + 16'(stall_byte)) begin
                    ready[i] = 1'b0;
                    stalled  = 1'b1;
                end
            end
            if (abort_byte >= 0 && we[i] && ram_addr[i] == b + 16'(abort_byte)) begin
                #1 rst_n[i] = 1'b0;
                #1;
                chk("abort_ram_we", i, 32'(we[i]), 32'h0);
                chk("abort_cpu_hold", i, 32'(hold[i]), 32'h1);
                chk("abort_busy", i, 32'(busy[i]), 32'h0);
                repeat (2) @(negedge clk);
                #1 rst_n[i] = 1'b1;
                fin = 1'b1;
            end else if (done[i]) begin
                fin = 1'b1;
            end else if (cyc >= limit) begin
                checks++;
                errors++;
                $display("FAIL done_timeout[inst %0d] no done after %0d cycles", i, cyc);
                fin = 1'b1;
            end
        end
    endtask

    task automatic check_image(input int i);
        for (int j = 0; j < 16; j++) begin
            logic [7:0] e;
            e = 8'(j) ^ 8'hA5;
            chk("ram_image", i, 32'(img[i][j]), 32'(e));
        end
    endtask

    task automatic reset_pulse(input int i);
        @(negedge clk);
        #1 rst_n[i] = 1'b0;
        #1;
        chk("async_ram_we", i, 32'(we[i]), 32'h0);
        chk("async_cpu_hold", i, 32'(hold[i]), 32'h1);
        chk("async_done", i, 32'(done[i]), 32'h0);
        repeat (2) @(negedge clk);
        #1 rst_n[i] = 1'b1;
    endtask

    // Autostart, backpressure and mid-copy reset (SIZE=16 == 2**ADDR_W).
    task automatic run_auto();
        int c;
        int unsigned w0;
        @(negedge clk);
        #1 rst_n[0] = 1'b1;
        w0 = wr_cnt[0];
        copy_run(0, -1, -1, -1, c);
        chk("auto_cycles", 0, c, 33);
        chk("auto_writes", 0, wr_cnt[0] - w0, 16);
        check_image(0);

        reset_pulse(0);
        w0 = wr_cnt[0];
        copy_run(0, 3, -1, -1, c);
        chk("stall_cycles", 0, c, 38);
        chk("stall_writes", 0, wr_cnt[0] - w0, 16);
        check_image(0);

        reset_pulse(0);
        w0 = wr_cnt[0];
        copy_run(0, -1, -1, 7, c);
        chk("abort_writes", 0, wr_cnt[0] - w0, 7);
        copy_run(0, -1, -1, -1, c);
        chk("restart_cycles", 0, c, 33);
        chk("restart_writes", 0, wr_cnt[0] - w0, 23);
        check_image(0);
    endtask

    // Manual start, start while busy, re-copy from DONE.
    task automatic run_manual();
        int c;
        @(negedge clk);
        #1 rst_n[1] = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_busy", 1, 32'(busy[1]), 32'h0);
        chk("idle_ram_we", 1, 32'(we[1]), 32'h0);
        chk("idle_cpu_hold", 1, 32'(hold[1]), 32'h1);
        chk("idle_writes", 1, wr_cnt[1], 0);
        #1 start[1] = 1'b1;
        copy_run(1, -1, 6, -1, c);
        chk("manual_cycles", 1, c, 33);
        chk("manual_last_addr", 1, 32'(last_addr[1]), 32'h100F);
        repeat (3) @(negedge clk);
        chk("done_sticky", 1, 32'(done[1]), 32'h1);
        chk("done_cpu_hold", 1, 32'(hold[1]), 32'h0);
        #1 start[1] = 1'b1;
        copy_run(1, -1, -1, -1, c);
        chk("recopy_cycles", 1, c, 33);
        chk("recopy_writes", 1, wr_cnt[1], 32);
        check_image(1);
    endtask

    task automatic run_single();
        int c;
        @(negedge clk);
        #1 rst_n[2] = 1'b1;
        copy_run(2, -1, -1, -1, c);
        chk("size1_cycles", 2, c, 3);
        repeat (5) @(negedge clk);
        chk("size1_writes", 2, wr_cnt[2], 1);
        chk("size1_addr", 2, 32'(last_addr[2]), 32'h4000);
        chk("size1_data", 2, 32'(img[2][0]), 32'hA5);
        chk("size1_done", 2, 32'(done[2]), 32'h1);
    endtask

    task automatic run_full();
        int c;
        @(negedge clk);
        #1 rst_n[3] = 1'b1;
        copy_run(3, -1, -1, -1, c);
        chk("full_cycles", 3, c, 24577);
        repeat (4) @(negedge clk);
        chk("full_writes", 3, wr_cnt[3], 32'h3000);
        chk("full_last_addr", 3, 32'(last_addr[3]), 32'h6FFF);
        chk("full_max_addr", 3, 32'(max_addr[3]), 32'h6FFF);
        chk("full_min_addr", 3, 32'(min_addr[3]), 32'h4000);
    endtask

`ifdef FIRMWARE_LOADER_CHECKSUM_EN
    task automatic run_csum(input int i);
        int c;
        @(negedge clk);
        #1 rst_n[i] = 1'b1;
        copy_run(i, -1, -1, -1, c);
        chk("csum_cycles", i, c, 513);
        chk("csum_value", i, 32'(csum[i]), 32'h00);
        chk("csum_ok", i, 32'(cok[i]), (i == 4) ? 32'h1 : 32'h0);
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) begin
            rst_n[i] = 1'b0;
            start[i] = 1'b0;
            ready[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk("rst_rom_address", i, 32'(rom_addr[i]), 32'h0);
            chk("rst_ram_address", i, 32'(ram_addr[i]), 32'(base_of(i)));
            chk("rst_ram_wdata", i, 32'(wdata[i]), 32'h0);
            chk("rst_ram_we", i, 32'(we[i]), 32'h0);
            chk("rst_busy", i, 32'(busy[i]), 32'h0);
            chk("rst_done", i, 32'(done[i]), 32'h0);
            chk("rst_cpu_hold", i, 32'(hold[i]), 32'h1);
        end
        fork
            run_auto();
            run_manual();
            run_single();
            run_full();
`ifdef FIRMWARE_LOADER_CHECKSUM_EN
            run_csum(4);
            run_csum(5);
`endif
        join
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
